// File: rtl/reg_mem_arbiter.sv
// Round-robin arbiter that serialises single read/write requests from NUM_REQ requesters
// onto one reg_mem port, using a three-state IDLE -> ACCESS -> RESP sequence.
module reg_mem_arbiter #(
   parameter int  DATA_WIDTH = 8,
   parameter int  ADDR_BITS  = 5,
   parameter int  NUM_REQ    = 2,
   localparam int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ-1:0]              req_we,
   input  logic [NUM_REQ*ADDR_BITS-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]              ack,
   output logic [DATA_WIDTH-1:0]           rdata,
   output logic                            busy,
   output logic [ID_W-1:0]                 grant_id,
   output logic [ADDR_BITS-1:0]            mem_addr,
   output logic [DATA_WIDTH-1:0]           mem_data_in,
   output logic                            mem_wen,
   input  logic [DATA_WIDTH-1:0]           mem_data_out
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

   state_t          state;
   logic [ID_W-1:0] last_grant;
   logic [ID_W-1:0] winner;

   // Walk offsets from far to near so the closest requester after last_grant wins.
   always_comb begin
      winner = last_grant;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req[(int'(last_grant) + k) % NUM_REQ]) begin
            winner = ID_W'((int'(last_grant) + k) % NUM_REQ);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= StIdle;
         last_grant  <= ID_W'(NUM_REQ - 1);
         grant_id    <= '0;
         mem_addr    <= '0;
         mem_data_in <= '0;
         mem_wen     <= 1'b0;
         ack         <= '0;
         rdata       <= '0;
         busy        <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               ack <= '0;
               if (|req) begin
                  grant_id    <= winner;
                  last_grant  <= winner;
                  mem_addr    <= req_addr[int'(winner)*ADDR_BITS +: ADDR_BITS];
                  mem_data_in <= req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                  mem_wen     <= req_we[winner];
                  busy        <= 1'b1;
                  state       <= StAccess;
               end
            end
            StAccess: begin
               // mem_wen still carries the latched direction of this access
               if (!mem_wen) begin
                  rdata <= mem_data_out;
               end
               mem_wen       <= 1'b0;
               ack[grant_id] <= 1'b1;
               state         <= StResp;
            end
            StResp: begin
               ack   <= '0;
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_mem_arbiter.sv
// Directed bench for reg_mem_arbiter with a behavioural reg_mem (async read, posedge write).
module tb_reg_mem_arbiter;

   localparam int DW = 8;
   localparam int AB = 5;
   localparam int NR = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NR-1:0]  req = '0;
   logic [NR-1:0]  req_we = '0;
   logic [NR*AB-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_wdata = '0;
   logic [NR-1:0]  ack;
   logic [DW-1:0]  rdata;
   logic           busy;
   logic [0:0]     grant_id;
   logic [AB-1:0]  mem_addr;
   logic [DW-1:0]  mem_data_in;
   logic           mem_wen;
   logic [DW-1:0]  mem_data_out;

   logic [DW-1:0]  mem [2**AB];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wen) mem[mem_addr] <= mem_data_in;
   end
   assign mem_data_out = mem[mem_addr];

   reg_mem_arbiter #(
      .DATA_WIDTH(DW),
      .ADDR_BITS (AB),
      .NUM_REQ   (NR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .ack         (ack),
      .rdata       (rdata),
      .busy        (busy),
      .grant_id    (grant_id),
      .mem_addr    (mem_addr),
      .mem_data_in (mem_data_in),
      .mem_wen     (mem_wen),
      .mem_data_out(mem_data_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Starts at a negedge with the FSM idle; returns at a negedge with the FSM idle again.
   task automatic txn(input int id, input logic we, input logic [AB-1:0] addr,
                      input logic [DW-1:0] wd, output logic [DW-1:0] rd, output int lat);
      logic seen;
      req_we[id]             = we;
      req_addr[id*AB +: AB]  = addr;
      req_wdata[id*DW +: DW] = wd;
      req[id]                = 1'b1;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 20) begin
         @(negedge clk);
         lat++;
         seen = ack[id];
      end
      check("ack_seen", 32'(seen), 1);
      rd      = rdata;
      req[id] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [DW-1:0] rd;
      int            lat;
      int            n;
      logic          prev;
      logic [NR-1:0] order [4];

      #2;
      check("rst_ack", 32'(ack), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_wen", 32'(mem_wen), 0);
      check("rst_rdata", 32'(rdata), 0);
      check("rst_grant", 32'(grant_id), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Contention straight out of reset: expect 0,1,0,1
      req_we = 2'b00;
      req_addr = {5'd1, 5'd0};
      req = 2'b11;
      n = 0;
      prev = 1'b0;
      for (int c = 0; c < 20 && n < 4; c++) begin
         @(negedge clk);
         if (ack != '0) begin
            check("ack_onehot", $countones(ack), 1);
            check("ack_width", 32'(prev), 0);
            order[n] = ack;
            n++;
            if (n == 4) req = 2'b00;
         end
         prev = (ack != '0);
      end
      req = 2'b00;
      check("rr_count", n, 4);
      check("rr_order0", 32'(order[0]), 32'h1);
      check("rr_order1", 32'(order[1]), 32'h2);
      check("rr_order2", 32'(order[2]), 32'h1);
      check("rr_order3", 32'(order[3]), 32'h2);
      @(negedge clk);
      check("ack_drop", 32'(ack), 0);

      // Single write then read
      txn(0, 1'b1, 5'd5, 8'h2A, rd, lat);
      check("wr_latency", lat, 2);
      txn(0, 1'b0, 5'd5, 8'h00, rd, lat);
      check("rd_latency", lat, 2);
      check("rd_data", 32'(rd), 32'h2A);

      // Full address sweep by requester 1
      for (int i = 0; i < 32; i++) txn(1, 1'b1, AB'(i), DW'(i % 10), rd, lat);
      for (int i = 0; i < 32; i++) begin
         txn(1, 1'b0, AB'(i), 8'h00, rd, lat);
         check($sformatf("sweep_%0d", i), 32'(rd), 32'(i % 10));
      end

      // Withdraw: req1 raised and dropped while req0 holds the port
      txn(0, 1'b1, 5'd9, 8'h3C, rd, lat);
      req_we = 2'b11;
      req_addr = {5'd9, 5'd10};
      req_wdata = {8'h55, 8'h01};
      req[0] = 1'b1;
      @(negedge clk);
      req[1] = 1'b1;
      @(negedge clk);
      check("wd_ack0", 32'(ack[0]), 1);
      req = 2'b00;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("wd_no_ack1", 32'(ack[1]), 0);
         check("wd_idle", 32'(busy), 0);
      end
      txn(0, 1'b0, 5'd9, 8'h00, rd, lat);
      check("wd_mem9", 32'(rd), 32'h3C);

      // Abort attempt: req0 dropped during ACCESS of a write
      req_we[0] = 1'b1;
      req_addr[0 +: AB] = 5'd3;
      req_wdata[0 +: DW] = 8'h77;
      req[0] = 1'b1;
      @(negedge clk);
      check("ab_wen", 32'(mem_wen), 1);
      req[0] = 1'b0;
      req_addr[0 +: AB] = 5'd0;
      req_wdata[0 +: DW] = 8'h00;
      @(negedge clk);
      check("ab_ack0", 32'(ack[0]), 1);
      @(negedge clk);
      txn(0, 1'b0, 5'd3, 8'h00, rd, lat);
      check("ab_mem3", 32'(rd), 32'h77);

      // Reset in the middle of a write
      txn(0, 1'b1, 5'd7, 8'h11, rd, lat);
      req_we[0] = 1'b1;
      req_addr[0 +: AB] = 5'd7;
      req_wdata[0 +: DW] = 8'hEE;
      req[0] = 1'b1;
      @(negedge clk);
      check("mr_wen_pre", 32'(mem_wen), 1);
      check("mr_rdata_pre", 32'(rdata), 32'h77);
      #2 rst = 1'b1;
      #1;
      check("mr_wen", 32'(mem_wen), 0);
      check("mr_ack", 32'(ack), 0);
      check("mr_busy", 32'(busy), 0);
      check("mr_rdata", 32'(rdata), 0);
      req[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      txn(0, 1'b0, 5'd7, 8'h00, rd, lat);
      check("mr_mem7", 32'(rd), 32'h11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
